// File: rtl/ysyx_24110015_mem_pkg.sv
// Shared definitions for the multi-cycle memory responder: FSM state
// encoding, default base address, bus widths and the byte-mask merge.
package ysyx_24110015_mem_pkg;

    localparam logic [31:0] DEF_ADDR_BASE = 32'h8000_0000;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned MASK_W        = DATA_W / 8;
    localparam int unsigned CNT_W         = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Replace only the bytes of old_w whose mask bit is set.
    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [MASK_W-1:0] mask
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < int'(MASK_W); i++) begin
            if (mask[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ysyx_24110015_mem_resp_if.sv
// Request/response channel between a memory requester (IFU/EXU path) and
// the memory responder.
//   req_*  : valid/ready request (wen, byte addr, wdata, byte mask)
//   rsp_*  : valid/ready response (rdata, err)
interface ysyx_24110015_mem_resp_if;
    import ysyx_24110015_mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [MASK_W-1:0] req_wmask;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/ysyx_24110015_sram_array.sv
// Synchronous single-port word array with byte-enable writes; no reset.
//   clk   : clock
//   en    : port access this cycle
//   we    : 1 = byte-masked write, 0 = read into rdata
//   idx   : word index
//   wmask : byte enables
//   wdata : write data
//   rdata : registered read data, held until the next read
module ysyx_24110015_sram_array
    import ysyx_24110015_mem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [MASK_W-1:0]     wmask,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    localparam int unsigned DEPTH = 32'(1) << DEPTH_LOG2;

    logic [DATA_W-1:0] mem [DEPTH];

    // Single port: either a merged write or a read per access.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[idx] <= byte_merge(mem[idx], wdata, wmask);
            else    rdata    <= mem[idx];
        end
    end

endmodule

// File: rtl/ysyx_24110015_mem_resp.sv
// Word-addressed memory responder with a fixed multi-cycle latency.
// One request is accepted in IDLE; storage is read or written at the
// accept edge; the response is presented LATENCY cycles later and held
// until the requester takes it.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of the request/response channel
module ysyx_24110015_mem_resp
    import ysyx_24110015_mem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE  = DEF_ADDR_BASE,
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    ysyx_24110015_mem_resp_if.slave  bus
);

    // One past the last valid byte offset; 33 bits so it never wraps.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(4) << DEPTH_LOG2;

    state_e                state;
    logic [CNT_W-1:0]      cnt;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic                  rd_hit_q;
    logic                  req_ready_c;
    logic                  accept_c;
    logic                  err_c;
    logic [ADDR_W-1:0]     off_c;
    logic [DEPTH_LOG2-1:0] idx_c;
    logic [DATA_W-1:0]     sram_rdata;

    // Range check: addresses below the base wrap to huge offsets.
    assign off_c = bus.req_addr - ADDR_BASE;
    assign err_c = {1'b0, off_c} >= LIMIT;
    assign idx_c = off_c[DEPTH_LOG2+1:2];

    assign req_ready_c = (state == S_IDLE) && !rst;
    assign accept_c    = bus.req_valid && req_ready_c;

    ysyx_24110015_sram_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_sram (
        .clk   (clk),
        .en    (accept_c && !err_c),
        .we    (bus.req_wen),
        .idx   (idx_c),
        .wmask (bus.req_wmask),
        .wdata (bus.req_wdata),
        .rdata (sram_rdata)
    );

    // Transaction FSM: IDLE -> (WAIT) -> RESP -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_hit_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept_c) begin
                        rsp_err_q <= err_c;
                        rd_hit_q  <= !bus.req_wen && !err_c;
                        if (LATENCY == 1) begin
                            state       <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            cnt         <= '0;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        state       <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rd_hit_q    <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read data is only valid for in-range reads; the array holds it stable.
    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rd_hit_q ? sram_rdata : '0;

endmodule

// File: tb/tb_ysyx_24110015_mem_resp.sv
// Bench for ysyx_24110015_mem_resp: three instances (LATENCY 2, 1, 4)
// driven from per-instance arrays; expected responses go through a queue.
module tb_ysyx_24110015_mem_resp;
    import ysyx_24110015_mem_pkg::*;

    typedef struct { logic [31:0] rdata; logic err; } exp_t;
    typedef struct { logic wen; logic [31:0] addr; logic [31:0] wdata; logic [3:0] mask;
                     logic [31:0] rdata; logic err; } op_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid [3];
    logic        req_wen   [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_wmask [3];
    logic        rsp_ready [3];
    logic        o_req_ready [3];
    logic        o_rsp_valid [3];
    logic        o_rsp_err   [3];
    logic [31:0] o_rsp_rdata [3];

    exp_t exp_q [3][$];
    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 3; g++) begin : gb
        ysyx_24110015_mem_resp_if bus ();
        assign bus.req_valid  = req_valid[g];
        assign bus.req_wen    = req_wen[g];
        assign bus.req_addr   = req_addr[g];
        assign bus.req_wdata  = req_wdata[g];
        assign bus.req_wmask  = req_wmask[g];
        assign bus.rsp_ready  = rsp_ready[g];
        assign o_req_ready[g] = bus.req_ready;
        assign o_rsp_valid[g] = bus.rsp_valid;
        assign o_rsp_err[g]   = bus.rsp_err;
        assign o_rsp_rdata[g] = bus.rsp_rdata;

        ysyx_24110015_mem_resp #(
            .ADDR_BASE  (32'h8000_0000),
            .DEPTH_LOG2 (12),
            .LATENCY    (g == 0 ? 2 : (g == 1 ? 1 : 4))
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    // Issue one request on instance s (call at a negedge); returns at the
    // negedge where rsp_valid is first seen. lat = posedges from accept to
    // the first posedge sampling rsp_valid high; -1/-2 on timeouts.
    task automatic run_txn(input int s, input op_t op, output int lat,
                           output logic [31:0] rd, output logic er);
        bit got;
        rd = '0; er = 1'b0;
        exp_q[s].push_back('{op.rdata, op.err});
        req_wen[s] = op.wen; req_addr[s] = op.addr;
        req_wdata[s] = op.wdata; req_wmask[s] = op.mask; req_valid[s] = 1'b1;
        got = 0;
        for (int i = 0; i < 64 && !got; i++) begin
            if (o_req_ready[s]) got = 1; else @(negedge clk);
        end
        if (!got) begin req_valid[s] = 1'b0; lat = -1; return; end
        @(posedge clk);
        @(negedge clk);
        req_valid[s] = 1'b0;
        lat = 1; got = 0;
        for (int i = 0; i < 64 && !got; i++) begin
            if (o_rsp_valid[s]) got = 1; else begin lat++; @(negedge clk); end
        end
        if (!got) begin lat = -2; return; end
        rd = o_rsp_rdata[s];
        er = o_rsp_err[s];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (o_req_ready[0] !== 1'b0 || o_rsp_valid[0] !== 1'b0 ||
                o_rsp_rdata[0] !== 32'h0 || o_rsp_err[0] !== 1'b0)
                begin bad++; $display("FAIL reset_outs got ready=%b valid=%b rdata=%h err=%b want 0/0/0/0",
                      o_req_ready[0], o_rsp_valid[0], o_rsp_rdata[0], o_rsp_err[0]); end
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (o_req_ready[0] !== 1'b1)
            begin bad++; $display("FAIL ready_after_reset got=%b want=1", o_req_ready[0]); end
    endtask

    task automatic test_read_after_write();
        op_t ops[2] = '{
            '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0},
            '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0}};
        int lat; logic [31:0] rd; logic er; exp_t e;
        foreach (ops[k]) begin
            run_txn(0, ops[k], lat, rd, er);
            e = exp_q[0].pop_front();
            total++;
            if (lat !== 2) begin bad++; $display("FAIL raw_lat[%0d] got=%0d want=2", k, lat); end
            total++;
            if (rd !== e.rdata || er !== e.err)
                begin bad++; $display("FAIL raw_data[%0d] got=%h/%b want=%h/%b", k, rd, er, e.rdata, e.err); end
            @(negedge clk);
            total++;
            if (o_req_ready[0] !== 1'b1 || o_rsp_valid[0] !== 1'b0)
                begin bad++; $display("FAIL raw_after_hs[%0d] got ready=%b valid=%b want 1/0",
                      k, o_req_ready[0], o_rsp_valid[0]); end
        end
    endtask

    task automatic test_byte_mask();
        op_t ops[3] = '{
            '{1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0101, 32'h0,         1'b0},
            '{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, 32'h0,         1'b0},
            '{1'b0, 32'h8000_0010, 32'h0,         4'h0,    32'hDE22_BE44, 1'b0}};
        int lat; logic [31:0] rd; logic er; exp_t e;
        foreach (ops[k]) begin
            run_txn(0, ops[k], lat, rd, er);
            e = exp_q[0].pop_front();
            total++;
            if (lat !== 2 || rd !== e.rdata || er !== e.err)
                begin bad++; $display("FAIL mask[%0d] got lat=%0d %h/%b want lat=2 %h/%b",
                      k, lat, rd, er, e.rdata, e.err); end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        op_t op = '{1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0};
        int lat; logic [31:0] rd; logic er; exp_t e;
        rsp_ready[0] = 1'b0;
        run_txn(0, op, lat, rd, er);
        e = exp_q[0].pop_front();
        total++;
        if (lat !== 2) begin bad++; $display("FAIL bp_lat got=%0d want=2", lat); end
        for (int c = 0; c < 5; c++) begin
            total++;
            if (o_rsp_valid[0] !== 1'b1 || o_rsp_rdata[0] !== e.rdata ||
                o_rsp_err[0] !== e.err || o_req_ready[0] !== 1'b0)
                begin bad++; $display("FAIL bp_hold[%0d] got valid=%b rdata=%h err=%b ready=%b want 1/%h/%b/0",
                      c, o_rsp_valid[0], o_rsp_rdata[0], o_rsp_err[0], o_req_ready[0], e.rdata, e.err); end
            if (c < 4) @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        total++;
        if (o_rsp_valid[0] !== 1'b0 || o_req_ready[0] !== 1'b1)
            begin bad++; $display("FAIL bp_release got valid=%b ready=%b want 0/1",
                  o_rsp_valid[0], o_req_ready[0]); end
    endtask

    task automatic test_range();
        op_t ops[7] = '{
            '{1'b1, 32'h8000_0000, 32'h0102_0304, 4'hF, 32'h0,         1'b0},
            '{1'b1, 32'h8000_3FFC, 32'hA5A5_A5A5, 4'hF, 32'h0,         1'b0},
            '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0,         1'b1},
            '{1'b0, 32'h8000_4000, 32'h0,         4'h0, 32'h0,         1'b1},
            '{1'b1, 32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1},
            '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'h0102_0304, 1'b0},
            '{1'b0, 32'h8000_3FFC, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0}};
        int lat; logic [31:0] rd; logic er; exp_t e;
        foreach (ops[k]) begin
            run_txn(0, ops[k], lat, rd, er);
            e = exp_q[0].pop_front();
            total++;
            if (lat !== 2 || rd !== e.rdata || er !== e.err)
                begin bad++; $display("FAIL range[%0d] got lat=%0d %h/%b want lat=2 %h/%b",
                      k, lat, rd, er, e.rdata, e.err); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals[4];
        op_t op; int lat; logic [31:0] rd; logic er; exp_t e;
        int nacc = 0, nrsp = 0, last_acc = -10;
        bit pend = 0;
        foreach (vals[k]) begin
            vals[k] = $urandom();
            op = '{1'b1, 32'h8000_0100 + 32'(4*k), vals[k], 4'hF, 32'h0, 1'b0};
            run_txn(1, op, lat, rd, er);
            e = exp_q[1].pop_front();
            total++;
            if (lat !== 1 || rd !== e.rdata || er !== e.err)
                begin bad++; $display("FAIL b2b_wr[%0d] got lat=%0d %h/%b want lat=1 %h/%b",
                      k, lat, rd, er, e.rdata, e.err); end
            @(negedge clk);
        end
        exp_q[1].push_back('{vals[0], 1'b0});
        req_wen[1] = 1'b0; req_addr[1] = 32'h8000_0100; req_valid[1] = 1'b1;
        for (int n = 0; n < 40 && nrsp < 4; n++) begin
            if (o_rsp_valid[1]) begin
                e = exp_q[1].pop_front();
                total++;
                if (o_rsp_rdata[1] !== e.rdata || o_rsp_err[1] !== e.err)
                    begin bad++; $display("FAIL b2b_data[%0d] got=%h/%b want=%h/%b",
                          nrsp, o_rsp_rdata[1], o_rsp_err[1], e.rdata, e.err); end
                total++;
                if (n !== last_acc + 1)
                    begin bad++; $display("FAIL b2b_rsp_lat[%0d] got=%0d want=1", nrsp, n - last_acc); end
                nrsp++;
            end
            if (pend) begin
                pend = 0;
                if (nacc < 4) begin
                    exp_q[1].push_back('{vals[nacc], 1'b0});
                    req_addr[1] = 32'h8000_0100 + 32'(4*nacc);
                end else req_valid[1] = 1'b0;
            end
            if (req_valid[1] && o_req_ready[1]) begin
                if (nacc > 0) begin
                    total++;
                    if (n !== last_acc + 2)
                        begin bad++; $display("FAIL b2b_spacing[%0d] got=%0d want=2", nacc, n - last_acc); end
                end
                last_acc = n; nacc++; pend = 1;
            end
            @(negedge clk);
        end
        req_valid[1] = 1'b0;
        total++;
        if (nacc !== 4 || nrsp !== 4)
            begin bad++; $display("FAIL b2b_count got acc=%0d rsp=%0d want 4/4", nacc, nrsp); end
    endtask

    task automatic test_reset_in_wait();
        op_t op = '{1'b0, 32'h8000_0020, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0};
        int lat; logic [31:0] rd; logic er; exp_t e;
        bit got = 0, seen = 0;
        rsp_ready[2] = 1'b1;
        req_wen[2] = 1'b1; req_addr[2] = 32'h8000_0020;
        req_wdata[2] = 32'hCAFE_F00D; req_wmask[2] = 4'hF; req_valid[2] = 1'b1;
        for (int i = 0; i < 64 && !got; i++) begin
            if (o_req_ready[2]) got = 1; else @(negedge clk);
        end
        total++;
        if (!got) begin bad++; $display("FAIL rw_accept got=timeout want=accept"); end
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (o_req_ready[2] !== 1'b0 || o_rsp_valid[2] !== 1'b0)
            begin bad++; $display("FAIL rw_in_reset got ready=%b valid=%b want 0/0",
                  o_req_ready[2], o_rsp_valid[2]); end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            if (o_rsp_valid[2]) seen = 1;
            @(negedge clk);
        end
        total++;
        if (seen) begin bad++; $display("FAIL rw_no_rsp got=valid seen want=none"); end
        run_txn(2, op, lat, rd, er);
        e = exp_q[2].pop_front();
        total++;
        if (lat !== 4 || rd !== e.rdata || er !== e.err)
            begin bad++; $display("FAIL rw_readback got lat=%0d %h/%b want lat=4 %h/%b",
                  lat, rd, er, e.rdata, e.err); end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 3; s++) begin
            req_valid[s] = 1'b0; req_wen[s] = 1'b0; req_addr[s] = '0;
            req_wdata[s] = '0; req_wmask[s] = '0; rsp_ready[s] = 1'b1;
        end
        test_reset();
        test_read_after_write();
        test_byte_mask();
        test_backpressure();
        test_range();
        test_back_to_back();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_24110015_mem_resp.md
Name: ysyx_24110015_mem_resp

Overview:
- Word-addressed memory responder: the target end of the fetch/load-store request interface driven by the core's IFU and EXU memory path.
- Accepts one request at a time over a valid/ready request channel.
- Performs a read or a byte-masked write against internal storage, then returns the result over a valid/ready response channel after a fixed, parameterised latency.
- Replaces the zero-latency combinational memory, so the core can be brought up against multi-cycle memory.

Parameters:
- ADDR_BASE, 32'h8000_0000, byte address of word 0.
- DEPTH_LOG2, 12, log2 of storage depth in 32-bit words (default 4096 words = 16 KiB).
- LATENCY, 2, cycles from request accept to first rsp_valid; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_wen  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address; bits [1:0] ignored.
- req_wdata  in  32  write data.
- req_wmask  in  4  byte enables; bit i enables wdata[8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts response.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  address outside [ADDR_BASE, ADDR_BASE + 4*2^DEPTH_LOG2).

Behaviour:
- Reset (rst high at posedge) forces:
  - state IDLE, counter 0;
  - rsp_valid 0, rsp_rdata 0, rsp_err 0;
  - req_ready 0 in any cycle where rst is high.
- Storage contents are not reset.
- States: IDLE, WAIT, RESP. State is encoded 2-bit; counter width is 4 bits.
- IDLE:
  - req_ready = 1 (when rst is low).
  - req_valid & req_ready at a posedge is the accept edge. It latches req_wen, the word index, and rsp_err.
- Index and range:
  - index = (req_addr - ADDR_BASE) >> 2, 32-bit unsigned subtract.
  - Out of range when the subtraction result is >= 4*2^DEPTH_LOG2. This includes addresses below ADDR_BASE, via wrap-around.
- Write:
  - Commits at the accept edge, only if in range. Only bytes with wmask = 1 change.
  - wmask = 0 is a legal no-op write that still produces a response.
- Read:
  - Data is sampled at the accept edge, so a read issued after a write response returns the new data.
- Accept-edge transition:
  - LATENCY = 1 → RESP.
  - Otherwise → WAIT with counter = LATENCY - 1.
- WAIT:
  - req_ready = 0; counter decrements each cycle.
  - When the counter reaches 1 → RESP.
  - Net effect: rsp_valid first rises exactly LATENCY cycles after the accept edge.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable until the handshake.
  - rsp_rdata = stored word for in-range reads, else 0.
  - rsp_valid & rsp_ready at a posedge → IDLE. req_ready is 1 in the following cycle.
- Request channel is ignored outside IDLE. The requester must hold req_* until accepted.
- rsp_ready may be high before rsp_valid; no combinational path from rsp_ready to rsp_valid or req_ready.
- Max throughput: one transaction per LATENCY + 1 cycles when rsp_ready is held high.
- Reset mid-transaction:
  - Transaction is abandoned; no response is issued.
  - A write already committed at its accept edge remains in storage.
- All outputs are registered or decoded from state only.

Decomposition:
- Shared package ysyx_24110015_mem_pkg holds:
  - state encoding constants IDLE/WAIT/RESP;
  - default ADDR_BASE;
  - mask width constant;
  - a function for byte-mask merge.
- One sub-module: ysyx_24110015_sram_array. It holds the synchronous single-port word array: read port, 4-bit byte-enable write, no reset.
- The FSM, counter and range check stay in the parent module.

Test Plan:
1. Reset and read after write:
   - Stimulus: hold rst 3 cycles, release; write 0xDEADBEEF, mask 4'hF, to 0x8000_0010; then read 0x8000_0010 (LATENCY = 2, rsp_ready = 1).
   - Required: req_ready 0 during reset, 1 after; each rsp_valid arrives exactly 2 cycles after its accept; read returns 0xDEADBEEF with rsp_err 0.
2. Byte mask:
   - Stimulus: after 0xDEADBEEF at 0x8000_0010, write 0x11223344 with mask 4'b0101, then read back.
   - Required: read returns 0xDE22BE44.
3. Backpressure:
   - Stimulus: read with rsp_ready low for 5 cycles after rsp_valid rises.
   - Required: rsp_valid and rsp_rdata stable for all 5 cycles; req_ready stays 0 until the cycle after the handshake.
4. Range errors:
   - Stimulus: read 0x7FFF_FFFC; read 0x8000_4000 (DEPTH_LOG2 = 12); write to 0x8000_4000; then read word 0.
   - Required: both reads return rsp_err = 1, rsp_rdata = 0; the error write leaves storage unchanged (word 0 and word 4095 unchanged).
5. LATENCY = 1 back-to-back:
   - Stimulus: set LATENCY = 1, rsp_ready high, req_valid held high for 4 reads.
   - Required: accepts occur every 2 cycles; each rsp_valid appears 1 cycle after its accept.
6. Reset in WAIT:
   - Stimulus: assert rst one cycle after accepting a write of 0xCAFEF00D to 0x8000_0020 (LATENCY = 4).
   - Required: no rsp_valid is ever issued for it; a subsequent read of 0x8000_0020 returns 0xCAFEF00D.
